// File: rtl/sq_cbrt_pkg.sv
`default_nettype none
// ============================================================================
// Package : sq_cbrt_pkg
// Shared widths, iteration count and FSM encoding for sq_cbrt_sum.
// Rev 1.0 : initial release
// ============================================================================
package sq_cbrt_pkg;

    localparam int OP_W       = 8;
    localparam int ROOT_W     = 4;
    localparam int RES_W      = 16;
    localparam int MULT_ITERS = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ADD    = 2'd3;

endpackage : sq_cbrt_pkg
`default_nettype wire

// File: rtl/cbrt.sv
`default_nettype none
// ============================================================================
// Module  : cbrt
// Iterative integer cube root of an 8-bit value, start/busy handshake.
// Rev 1.0 : initial release
// ============================================================================
module cbrt (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    output logic       busy,
    output logic [3:0] root
);

    logic        busy_q;
    logic [3:0]  root_q;
    logic [7:0]  a_q;
    logic [3:0]  w_next;
    logic [11:0] w_cube;

    assign w_next = root_q + 4'd1;
    assign w_cube = 12'(w_next) * 12'(w_next) * 12'(w_next);

    // Step the candidate upward while its successor's cube still fits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            root_q <= '0;
            a_q    <= '0;
        end else if (start && !busy_q) begin
            busy_q <= 1'b1;
            root_q <= '0;
            a_q    <= a;
        end else if (busy_q) begin
            if (w_cube <= {4'd0, a_q}) begin
                root_q <= w_next;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign root = root_q;

endmodule : cbrt
`default_nettype wire

// File: rtl/mult8.sv
`default_nettype none
// ============================================================================
// Module  : mult8
// 8x8 shift-add multiplier, one partial product per cycle, done pulse.
// Rev 1.0 : initial release
// ============================================================================
module mult8
    import sq_cbrt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [OP_W-1:0]  x_i,
    input  logic [OP_W-1:0]  y_i,
    output logic             done_o,
    output logic [RES_W-1:0] product_o
);

    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] mcand_q;
    logic [OP_W-1:0]  mplier_q;
    logic [3:0]       cnt_q;
    logic             active_q;
    logic             done_q;

    // The start edge already folds in bit 0, so done lands on the 8th edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q    <= y_i[0] ? {8'd0, x_i} : '0;
                mcand_q  <= {7'd0, x_i, 1'b0};
                mplier_q <= {1'b0, y_i[OP_W-1:1]};
                cnt_q    <= 4'd1;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 4'd1;
                if (cnt_q == 4'(MULT_ITERS - 1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule : mult8
`default_nettype wire

// File: rtl/sq_cbrt_sum.sv
`default_nettype none
// ============================================================================
// Module  : sq_cbrt_sum
// Computes y = a*a + cbrt(b); square and cube root run concurrently.
// Rev 1.0 : initial release
// ============================================================================
module sq_cbrt_sum
    import sq_cbrt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             busy,
    output logic [RES_W-1:0] y
);

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   a_r_q, a_r_d;
    logic [OP_W-1:0]   b_r_q, b_r_d;
    logic              sq_done_q, sq_done_d;
    logic              rt_done_q, rt_done_d;
    logic              busy_q, busy_d;
    logic [RES_W-1:0]  y_q, y_d;

    logic              w_cbrt_start;
    logic              w_cbrt_busy;
    logic [ROOT_W-1:0] w_root;
    logic              w_mult_start;
    logic              w_mult_done;
    logic [RES_W-1:0]  w_product;

    always_comb begin
        state_d      = state_q;
        a_r_d        = a_r_q;
        b_r_d        = b_r_q;
        sq_done_d    = sq_done_q;
        rt_done_d    = rt_done_q;
        busy_d       = busy_q;
        y_d          = y_q;
        w_cbrt_start = 1'b0;
        w_mult_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_r_d   = a;
                    b_r_d   = b;
                    busy_d  = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_cbrt_start = 1'b1;
                w_mult_start = 1'b1;
                sq_done_d    = 1'b0;
                rt_done_d    = 1'b0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                sq_done_d = sq_done_q | w_mult_done;
                rt_done_d = rt_done_q | ~w_cbrt_busy;
                if (sq_done_d && rt_done_d) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                y_d     = w_product + {12'd0, w_root};
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_r_q     <= '0;
            b_r_q     <= '0;
            sq_done_q <= 1'b0;
            rt_done_q <= 1'b0;
            busy_q    <= 1'b0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            a_r_q     <= a_r_d;
            b_r_q     <= b_r_d;
            sq_done_q <= sq_done_d;
            rt_done_q <= rt_done_d;
            busy_q    <= busy_d;
            y_q       <= y_d;
        end
    end

    mult8 u_mult8 (
        .clk       (clk),
        .reset     (reset),
        .start_i   (w_mult_start),
        .x_i       (a_r_q),
        .y_i       (a_r_q),
        .done_o    (w_mult_done),
        .product_o (w_product)
    );

    cbrt u_cbrt (
        .clk   (clk),
        .reset (reset),
        .start (w_cbrt_start),
        .a     (b_r_q),
        .busy  (w_cbrt_busy),
        .root  (w_root)
    );

    assign busy = busy_q;
    assign y    = y_q;

endmodule : sq_cbrt_sum
`default_nettype wire

// File: tb/tb_sq_cbrt_sum.sv
`default_nettype none
// ============================================================================
// Module  : tb_sq_cbrt_sum
// Directed self-checking bench for sq_cbrt_sum.
// Rev 1.0 : initial release
// ============================================================================
module tb_sq_cbrt_sum;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic [15:0] y;

    int pass_cnt;
    int total_cnt;

    sq_cbrt_sum dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle start pulse; reports busy after the accepting edge,
    // the number of cycles busy stayed high, and the final y.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output logic rose, output int cyc,
                          output logic [15:0] yv);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        rose = busy;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        yv = y;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        #12;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (y !== 16'd0) $display("FAIL reset_y got %0d want 0", y);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic rose; int cyc; logic [15:0] yv;
        run_op(8'd3, 8'd27, rose, cyc, yv);
        total_cnt++;
        if (rose !== 1'b1) $display("FAIL basic_busy_rise got %0b want 1", rose);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 10) $display("FAIL basic_latency got %0d want 10", cyc);
        else pass_cnt++;
        total_cnt++;
        if (yv !== 16'd12) $display("FAIL basic_y got %0d want 12", yv);
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [7:0]  va [4] = '{8'd0, 8'd255, 8'd10, 8'd15};
        logic [7:0]  vb [4] = '{8'd0, 8'd255, 8'd8,  8'd215};
        logic [15:0] ve [4] = '{16'd0, 16'd65031, 16'd102, 16'd230};
        logic rose; int cyc; logic [15:0] yv;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], rose, cyc, yv);
            total_cnt++;
            if (yv !== ve[i])
                $display("FAIL vec%0d_y a=%0d b=%0d got %0d want %0d", i, va[i], vb[i], yv, ve[i]);
            else pass_cnt++;
            total_cnt++;
            if (cyc != 10) $display("FAIL vec%0d_latency got %0d want 10", i, cyc);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_busy();
        int cyc; int extra;
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd27;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        total_cnt++;
        if (y !== 16'd12) $display("FAIL ignore_y got %0d want 12", y);
        else pass_cnt++;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL ignore_no_second_op got %0d busy cycles want 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (y !== 16'd12) $display("FAIL ignore_y_held got %0d want 12", y);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc; int idle;
        @(negedge clk);
        start = 1'b1; a = 8'd2; b = 8'd64;
        @(negedge clk);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        total_cnt++;
        if (y !== 16'd8) $display("FAIL b2b_first_y got %0d want 8", y);
        else pass_cnt++;
        a = 8'd4; b = 8'd125;
        idle = 0;
        while (!busy && idle < 100) begin
            idle++;
            @(negedge clk);
        end
        total_cnt++;
        if (idle != 1) $display("FAIL b2b_idle_cycles got %0d want 1", idle);
        else pass_cnt++;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++;
        if (y !== 16'd21) $display("FAIL b2b_second_y got %0d want 21", y);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 10) $display("FAIL b2b_second_latency got %0d want 10", cyc);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic rose; int cyc; logic [15:0] yv;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midreset_busy got %0b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (y !== 16'd0) $display("FAIL midreset_y got %0d want 0", y);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        run_op(8'd5, 8'd1, rose, cyc, yv);
        total_cnt++;
        if (yv !== 16'd26) $display("FAIL postreset_y got %0d want 26", yv);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 10) $display("FAIL postreset_latency got %0d want 10", cyc);
        else pass_cnt++;
    endtask

    task automatic test_stable();
        int bad_y; int bad_busy;
        bad_y = 0; bad_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = 8'(i * 37 + 1); b = 8'(255 - i * 19);
            @(posedge clk);
            #1;
            if (y !== 16'd26) bad_y++;
            if (busy !== 1'b0) bad_busy++;
        end
        total_cnt++;
        if (bad_y != 0) $display("FAIL stable_y got %0d changed samples want 0 (y=%0d)", bad_y, y);
        else pass_cnt++;
        total_cnt++;
        if (bad_busy != 0) $display("FAIL stable_busy got %0d busy samples want 0", bad_busy);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_stable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_sq_cbrt_sum
`default_nettype wire

// File: doc/sq_cbrt_sum.md
Name: sq_cbrt_sum

Overview:
Sequential function unit computing y = a*a + cbrt(b) for 8-bit unsigned a and b.
- Sits directly upstream of cbrt: drives cbrt's start/a handshake, consumes root, and adds it to a square from an internal shift-add multiplier.
- The squaring and the cube root run concurrently.
- Top-level compute block of the lab; cbrt is instantiated unchanged.

Parameters:
None. Widths are fixed: 8-bit operands, 16-bit result. The maximum result 255*255 + 6 = 65031 fits in 16 bits.

Ports:
clk    input   1   system clock, rising edge
reset  input   1   asynchronous, active-high reset
start  input   1   request; sampled only while busy=0
a      input   8   operand to square (unsigned)
b      input   8   operand for cube root (unsigned)
busy   output  1   high from the edge that accepts start until the result edge
y      output  16  result; valid and held while busy=0 after a completed operation

Behaviour:
- Reset (asynchronous, mid-operation included):
  - state=IDLE, busy=0, y=0; latched operands, sticky flags and mult8 are cleared.
  - The cbrt instance shares the same reset, so any in-flight root computation is aborted.
  - Operation resumes only on a fresh start after reset deasserts.
- cbrt handshake contract:
  - cbrt start is a one-cycle pulse driven only while cbrt busy=0.
  - cbrt busy rises at the edge that samples its start.
  - cbrt root is valid from the cycle its busy falls and is held until the next start.
- FSM states: IDLE, LAUNCH, WAIT, ADD.
- IDLE:
  - busy=0; y holds its last value.
  - On start=1 at an edge: latch a→a_r, b→b_r; busy←1; go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Drive cbrt.start=1 and cbrt.a=b_r combinationally.
  - Drive mult8.start=1 with x=a_r, y=a_r.
  - Clear sticky flags sq_done and rt_done; go to WAIT.
- WAIT:
  - sq_done ← 1 when mult8.done=1.
  - rt_done ← 1 when cbrt.busy=0. cbrt.busy is already high in the first WAIT cycle.
  - Go to ADD when both flags are set, counting a flag being set in the current cycle.
- ADD (1 cycle):
  - y ← {8'b0 product} + {12'b0, root}, 16-bit and never overflowing.
  - busy←0; go to IDLE. y and busy update at the same edge.
- Latency from the accepting edge to the busy-falling edge = 2 + max(8, Lc) cycles, where Lc is the cbrt busy duration in cycles.
- Boundary cases:
  - start while busy=1: ignored, no queuing; a and b are not re-sampled.
  - start held high continuously: a new operation is accepted on the edge after busy falls (back-to-back, one IDLE cycle).
  - a=0 or b=0: no shortcut; latency is unchanged (mult8 has fixed latency).
  - Input changes on a and b after acceptance: no effect.
- mult8:
  - 8-bit x 8-bit shift-add, 16-bit product.
  - Exactly 8 iterations, one per cycle.
  - done is a one-cycle pulse at the 8th cycle after start; product is held until the next start.

Decomposition:
- Shared package sq_cbrt_pkg:
  - FSM state encoding (IDLE=0, LAUNCH=1, WAIT=2, ADD=3).
  - Width constants OP_W=8, ROOT_W=4, RES_W=16.
  - Constant MULT_ITERS=8.
- One natural sub-module: mult8, the shift-add multiplier with a start/done pulse interface.
- cbrt is instantiated as-is; it is not re-implemented.

Test Plan:
- reset, then a=3, b=27, pulse start → busy high at next edge; after busy falls, y=12; busy duration = 2+max(8,Lc) cycles.
- a=0, b=0 → y=0; a=255, b=255 → y=65031; a=10, b=8 → y=102; a=15, b=215 → y=230.
- pulse start again with a=1, b=1 while busy → ignored; the first op (a=3, b=27) still yields y=12, and no second operation follows.
- start held high through two ops (a=2, b=64, then a=4, b=125 presented after the first busy falls) → y=8 then y=21, with exactly one IDLE cycle between.
- assert reset mid-WAIT during a=200, b=200 → busy=0 and y=0 immediately (asynchronous); the next op a=5, b=1 → y=26.
- y stability: change a and b and toggle inputs while idle with start=0 → y and busy unchanged.
